sp_cbus_master: RTL and testbench

Initiator for the single-port memory cbus: accepts read/write commands from a local host into a small command queue, presents them on the cbus toward the single-port memory arbiter, and holds each request stable while the PHY owns the memory. Read data is captured from the SRAM output one cycle after the arbiter grants the read and returned to the host as a registered response. The block also raises a starvation indication and a sticky protocol-error flag.

---
 rtl/sp_cbus_pkg.sv | 12 +
 rtl/sp_cbus_fifo.sv | 63 ++++++
 rtl/sp_cbus_master.sv | 130 +++++++++++++
 tb/tb_sp_cbus_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_cbus_pkg.sv
// Shared encodings for the single-port memory cbus initiator.
package sp_cbus_pkg;

   localparam logic CBUS_CMD_WR = 1'b0;
   localparam logic CBUS_CMD_RD = 1'b1;

   typedef enum logic [0:0] {
      StIdle,
      StReq
   } cbus_state_e;

endpackage

// File: rtl/sp_cbus_fifo.sv
// Register-based synchronous FIFO with occupancy count; head is read through a mux.
module sp_cbus_fifo #(
   parameter int unsigned Width = 65,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [Width-1:0]           wdata,
   input  logic                       pop,
   output logic [Width-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth+1)-1:0] count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_en, pop_en;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Depth is a power of two, so pointers wrap naturally.
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_en && !pop_en) begin
         count_d = count_q + 1'b1;
      end else if (!push_en && pop_en) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/sp_cbus_master.sv
// cbus initiator: queues host commands, issues them to the memory arbiter, returns read data.
module sp_cbus_master
   import sp_cbus_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned STALL_MAX = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       host_valid,
   output logic                       host_ready,
   input  logic                       host_cmd,
   input  logic [AW-1:0]              host_addr,
   input  logic [DW-1:0]              host_wrdata,
   output logic                       rsp_valid,
   output logic [DW-1:0]              rsp_rddata,
   output logic                       wr_done,
   output logic                       cbus_req,
   output logic                       cbus_cmd,
   output logic [AW-1:0]              cbus_addr,
   output logic [DW-1:0]              cbus_wrdata,
   input  logic                       cbus_waccept,
   input  logic                       cbus_rresp,
   input  logic [DW-1:0]              mem_rddata,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       starve,
   output logic                       proto_err
);

   localparam int unsigned EntW   = 1 + AW + DW;
   localparam int unsigned CntW   = $clog2(DEPTH + 1);
   localparam int unsigned StallW = $clog2(STALL_MAX + 1);

   cbus_state_e       state_q, state_d;
   logic [StallW-1:0] stall_q, stall_d;
   logic [EntW-1:0]   head;
   logic [CntW-1:0]   count;
   logic              full, empty, push;
   logic              head_cmd;
   logic [AW-1:0]     head_addr;
   logic [DW-1:0]     head_wrdata;
   logic              wr_grant, rd_grant, grant, bad_grant;
   logic              wr_done_q, rd_inflight_q, rsp_valid_q, proto_err_q;
   logic [DW-1:0]     rsp_rddata_q;

   assign push = host_valid & ~full;

   sp_cbus_fifo #(
      .Width (EntW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({host_cmd, host_addr, host_wrdata}),
      .pop   (grant),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign head_cmd    = head[EntW-1];
   assign head_addr   = head[DW +: AW];
   assign head_wrdata = head[DW-1:0];

   assign cbus_req  = (state_q == StReq);
   assign wr_grant  = cbus_req & (head_cmd == CBUS_CMD_WR) & cbus_waccept;
   assign rd_grant  = cbus_req & (head_cmd == CBUS_CMD_RD) & cbus_rresp;
   assign grant     = wr_grant | rd_grant;
   // A grant that does not match the presented head is ignored apart from the error flag.
   assign bad_grant = (cbus_waccept & (~cbus_req | (head_cmd == CBUS_CMD_RD))) |
                      (cbus_rresp   & (~cbus_req | (head_cmd == CBUS_CMD_WR)));

   always_comb begin
      state_d = state_q;
      stall_d = '0;
      unique case (state_q)
         StIdle: begin
            if (push || !empty) state_d = StReq;
         end
         StReq: begin
            if (grant) begin
               if (count == CntW'(1) && !push) state_d = StIdle;
            end else if (stall_q != StallW'(STALL_MAX)) begin
               stall_d = stall_q + 1'b1;
            end else begin
               stall_d = stall_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         stall_q       <= '0;
         wr_done_q     <= 1'b0;
         rd_inflight_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rddata_q  <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_q       <= stall_d;
         wr_done_q     <= wr_grant;
         rd_inflight_q <= rd_grant;
         rsp_valid_q   <= rd_inflight_q;
         if (rd_inflight_q) rsp_rddata_q <= mem_rddata;
         if (bad_grant)     proto_err_q  <= 1'b1;
      end
   end

   assign host_ready  = ~full;
   assign cbus_cmd    = cbus_req ? head_cmd    : 1'b0;
   assign cbus_addr   = cbus_req ? head_addr   : '0;
   assign cbus_wrdata = cbus_req ? head_wrdata : '0;
   assign wr_done     = wr_done_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rddata  = rsp_rddata_q;
   assign busy        = ~empty | rd_inflight_q;
   assign pending     = count;
   assign starve      = (stall_q >= StallW'(STALL_MAX));
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_sp_cbus_master.sv
// Directed bench for sp_cbus_master with hand-computed expectations.
module tb_sp_cbus_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DEPTH = 4;
   localparam int STALL_MAX = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          host_cmd = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wrdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rddata;
   logic          wr_done;
   logic          cbus_req;
   logic          cbus_cmd;
   logic [AW-1:0] cbus_addr;
   logic [DW-1:0] cbus_wrdata;
   logic          cbus_waccept = 1'b0;
   logic          cbus_rresp = 1'b0;
   logic [DW-1:0] mem_rddata = '0;
   logic          busy;
   logic [2:0]    pending;
   logic          starve;
   logic          proto_err;

   int n_cmp = 0;
   int n_bad = 0;

   sp_cbus_master #(
      .DW        (DW),
      .AW        (AW),
      .DEPTH     (DEPTH),
      .STALL_MAX (STALL_MAX)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_cmd     (host_cmd),
      .host_addr    (host_addr),
      .host_wrdata  (host_wrdata),
      .rsp_valid    (rsp_valid),
      .rsp_rddata   (rsp_rddata),
      .wr_done      (wr_done),
      .cbus_req     (cbus_req),
      .cbus_cmd     (cbus_cmd),
      .cbus_addr    (cbus_addr),
      .cbus_wrdata  (cbus_wrdata),
      .cbus_waccept (cbus_waccept),
      .cbus_rresp   (cbus_rresp),
      .mem_rddata   (mem_rddata),
      .busy         (busy),
      .pending      (pending),
      .starve       (starve),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_host(input logic v, input logic c, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
      host_valid  = v;
      host_cmd    = c;
      host_addr   = a;
      host_wrdata = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", host_ready); end
      n_cmp++; if (cbus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0b want 0", cbus_req); end
      n_cmp++; if (rsp_rddata !== 32'h0) begin n_bad++; $display("FAIL rst_rddata: got %h want 0", rsp_rddata); end
      n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL rst_pending: got %0d want 0", pending); end
      n_cmp++; if ({busy, starve, proto_err, rsp_valid, wr_done} !== 5'b0) begin
         n_bad++; $display("FAIL rst_flags: got %b want 00000", {busy, starve, proto_err, rsp_valid, wr_done});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write();
      drive_host(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      step();
      drive_host(1'b0, 1'b0, '0, '0);
      n_cmp++; if ({cbus_req, cbus_cmd} !== 2'b10) begin n_bad++; $display("FAIL wr_req: got %b want 10", {cbus_req, cbus_cmd}); end
      n_cmp++; if (cbus_addr !== 32'h10) begin n_bad++; $display("FAIL wr_addr: got %h want 10", cbus_addr); end
      n_cmp++; if (cbus_wrdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_data: got %h want deadbeef", cbus_wrdata); end
      n_cmp++; if (pending !== 3'd1) begin n_bad++; $display("FAIL wr_pending1: got %0d want 1", pending); end
      cbus_waccept = 1'b1;
      step();
      cbus_waccept = 1'b0;
      n_cmp++; if (wr_done !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %0b want 1", wr_done); end
      n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL wr_pending0: got %0d want 0", pending); end
      n_cmp++; if (cbus_req !== 1'b0) begin n_bad++; $display("FAIL wr_req_drop: got %0b want 0", cbus_req); end
      step();
      n_cmp++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL wr_done_pulse: got %0b want 0", wr_done); end
   endtask

   task automatic test_read();
      drive_host(1'b1, 1'b1, 32'h20, '0);
      step();
      drive_host(1'b0, 1'b0, '0, '0);
      n_cmp++; if ({cbus_req, cbus_cmd} !== 2'b11) begin n_bad++; $display("FAIL rd_req: got %b want 11", {cbus_req, cbus_cmd}); end
      n_cmp++; if (cbus_addr !== 32'h20) begin n_bad++; $display("FAIL rd_addr: got %h want 20", cbus_addr); end
      cbus_rresp = 1'b1;
      step();
      cbus_rresp = 1'b0;
      mem_rddata = 32'hCAFEF00D;
      n_cmp++; if ({rsp_valid, busy, cbus_req} !== 3'b010) begin
         n_bad++; $display("FAIL rd_inflight: got %b want 010", {rsp_valid, busy, cbus_req});
      end
      step();
      mem_rddata = 32'h0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid: got %0b want 1", rsp_valid); end
      n_cmp++; if (rsp_rddata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rd_data: got %h want cafef00d", rsp_rddata); end
      step();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_pulse: got %0b want 0", rsp_valid); end
      n_cmp++; if (rsp_rddata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rd_data_hold: got %h want cafef00d", rsp_rddata); end
   endtask

   task automatic test_stall();
      drive_host(1'b1, 1'b0, 32'h30, 32'h12345678);
      step();
      drive_host(1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 20; k++) begin
         n_cmp++; if ({cbus_req, cbus_cmd, cbus_addr, cbus_wrdata} !== {2'b10, 32'h30, 32'h12345678}) begin
            n_bad++; $display("FAIL stall_hold[%0d]: got %b %h %h want 10 30 12345678", k, {cbus_req, cbus_cmd}, cbus_addr, cbus_wrdata);
         end
         n_cmp++; if (starve !== (k >= STALL_MAX)) begin
            n_bad++; $display("FAIL stall_starve[%0d]: got %0b want %0b", k, starve, (k >= STALL_MAX));
         end
         if (k == 19) cbus_waccept = 1'b1;
         step();
      end
      cbus_waccept = 1'b0;
      n_cmp++; if ({starve, wr_done, cbus_req} !== 3'b010) begin
         n_bad++; $display("FAIL stall_clear: got %b want 010", {starve, wr_done, cbus_req});
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, host_ready); end
         drive_host(1'b1, 1'b0, 32'h100 + i, 32'hA0 + i);
         step();
      end
      drive_host(1'b1, 1'b0, 32'h104, 32'hA4);
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b want 0", host_ready); end
      n_cmp++; if (pending !== 3'd4) begin n_bad++; $display("FAIL full_pending: got %0d want 4", pending); end
      cbus_waccept = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({cbus_req, cbus_addr, cbus_wrdata} !== {1'b1, 32'h100 + i, 32'hA0 + i}) begin
            n_bad++; $display("FAIL b2b_head[%0d]: got %0b %h %h want 1 %h %h", i, cbus_req, cbus_addr, cbus_wrdata, 32'h100 + i, 32'hA0 + i);
         end
         n_cmp++; if (wr_done !== (i > 0)) begin n_bad++; $display("FAIL b2b_done[%0d]: got %0b want %0b", i, wr_done, (i > 0)); end
         step();
         if (i == 1) drive_host(1'b0, 1'b0, '0, '0);
      end
      cbus_waccept = 1'b0;
      n_cmp++; if ({cbus_req, wr_done, pending} !== {2'b01, 3'd0}) begin
         n_bad++; $display("FAIL b2b_drain: got %b %0d want 01 0", {cbus_req, wr_done}, pending);
      end
      step();
   endtask

   task automatic test_proto();
      drive_host(1'b1, 1'b0, 32'h40, 32'h55);
      step();
      drive_host(1'b0, 1'b0, '0, '0);
      n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL proto_pre: got %0b want 0", proto_err); end
      cbus_rresp = 1'b1;
      step();
      cbus_rresp = 1'b0;
      n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_set: got %0b want 1", proto_err); end
      n_cmp++; if ({cbus_req, pending, cbus_addr} !== {1'b1, 3'd1, 32'h40}) begin
         n_bad++; $display("FAIL proto_queue: got %0b %0d %h want 1 1 40", cbus_req, pending, cbus_addr);
      end
      step();
      n_cmp++; if ({rsp_valid, proto_err} !== 2'b01) begin
         n_bad++; $display("FAIL proto_sticky: got %b want 01", {rsp_valid, proto_err});
      end
      cbus_waccept = 1'b1;
      step();
      cbus_waccept = 1'b0;
      n_cmp++; if ({pending, proto_err, wr_done} !== {3'd0, 2'b11}) begin
         n_bad++; $display("FAIL proto_drain: got %0d %b want 0 11", pending, {proto_err, wr_done});
      end
      step();
   endtask

   task automatic test_reset_midflight();
      drive_host(1'b1, 1'b1, 32'h50, '0);
      step();
      drive_host(1'b1, 1'b0, 32'h60, 32'h66);
      cbus_rresp = 1'b1;
      step();
      drive_host(1'b0, 1'b0, '0, '0);
      cbus_rresp = 1'b0;
      mem_rddata = 32'h13579BDF;
      n_cmp++; if ({cbus_req, cbus_addr, busy} !== {1'b1, 32'h60, 1'b1}) begin
         n_bad++; $display("FAIL mid_pre: got %0b %h %0b want 1 60 1", cbus_req, cbus_addr, busy);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({cbus_req, cbus_cmd, cbus_addr, cbus_wrdata} !== '0) begin
         n_bad++; $display("FAIL mid_cbus: got %0b %h %h want 0 0 0", cbus_req, cbus_addr, cbus_wrdata);
      end
      n_cmp++; if ({busy, pending, proto_err, host_ready, rsp_rddata} !== {1'b0, 3'd0, 1'b0, 1'b1, 32'h0}) begin
         n_bad++; $display("FAIL mid_state: got %0b %0d %0b %0b %h want 0 0 0 1 0", busy, pending, proto_err, host_ready, rsp_rddata);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if ({rsp_valid, wr_done, cbus_req} !== 3'b000) begin
            n_bad++; $display("FAIL mid_after[%0d]: got %b want 000", i, {rsp_valid, wr_done, cbus_req});
         end
      end
      mem_rddata = 32'h0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_back_to_back();
      test_proto();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
